stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Registered N-channel stream multiplexer with valid/ready handshaking on every input and on the output. It is the parametrised successor of the fixed 4:1 combinational byte mux. It adds configurable data width and channel count, a selectable fixed-select or round-robin arbitration mode, and a one-word output register with full backpressure. It sits between multiple producers and a single shared consumer, such as a bus, UART or memory port.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- N, 4, number of input channels (2..16)
- SEL_W, $clog2(N), derived localparam, width of channel indices; not overridden

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready, at most one bit high
- mode  input  1  0 = fixed select via sel, 1 = round-robin
- sel  input  SEL_W  channel index used when mode = 0
- out_data  output  WIDTH  held word
- out_chan  output  SEL_W  source channel of held word
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word

## Operation
- Storage is one output register {out_data, out_chan, out_valid} plus a round-robin pointer ptr[SEL_W].
- load_en = !out_valid || out_ready. A word can be loaded when the register is empty or is being popped in the same cycle.
- Grant selection (combinational):
  - mode 0: grant = sel, and only if sel < N and in_valid[sel]. Otherwise there is no grant.
  - mode 1: the grant goes to the first i with in_valid[i] set, scanning ptr, ptr+1, … modulo N. If no input is valid, there is no grant.
- in_ready[i] = load_en && grant valid && grant == i. A transfer on channel i is in_valid[i] && in_ready[i].
- On a transfer:
  - out_data <= that channel's word.
  - out_chan <= i.
  - out_valid <= 1.
  - ptr <= (i + 1) mod N. This happens in both modes, so a switch to mode 1 resumes fairly.
- A pop with no transfer (out_valid && out_ready and no grant) sets out_valid <= 0. out_data and out_chan keep their last values.
- While out_valid && !out_ready:
  - out_data, out_chan and out_valid hold stable.
  - All in_ready bits are 0.
- Changes to sel or mode never alter a word already held. They affect only the next arbitration.
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0. Reset mid-operation discards any held word. in_ready is 0 during reset.
- Non-power-of-2 N:
  - A sel value >= N grants nothing.
  - ptr wraps from N-1 to 0, never to N.

## Timing
- Latency: a word accepted at edge k is visible on out_data with out_valid = 1 after edge k, so it can be popped at edge k+1.
- Throughput: one word per cycle sustained while out_ready = 1 and some granted input is valid. There are no bubbles.
- in_ready depends combinationally on out_ready, in_valid, mode, sel and registered state. There is no combinational path from in_data to any output.
- Valid/ready rules:
  - The producer must hold in_data stable while in_valid && !in_ready.
  - The block never drops out_valid without a pop.
- Simultaneous pop and load in the same cycle: the new word replaces the old one and out_valid stays 1.
- Round-robin fairness: with all N inputs continuously valid and out_ready = 1, grants cycle 0, 1, …, N-1, 0 with no repeats.

## Test plan
- Reset: assert rst for 2 cycles with all inputs valid. Required: out_valid = 0, out_data = 0, in_ready = 0. On the first cycle after release, ptr = 0 and channel 0 is granted in mode 1.
- Fixed select with N = 4, WIDTH = 8: set mode = 0, sel = 2, d2 = 0xA5 valid, out_ready = 1. Required: in_ready = 4'b0100, and one cycle later out_data = 0xA5, out_chan = 2. With sel = 3 and in_valid[3] = 0, no transfer occurs and out_valid falls after the pop.
- Round-robin: set mode = 1, all four inputs valid with words 0x10..0x13, out_ready = 1 for 8 cycles. Required: out_chan sequence 0, 1, 2, 3, 0, 1, 2, 3 with matching data.
- Backpressure: hold a word 0x33 with out_ready = 0 for 5 cycles while changing sel and data. Required: out_data = 0x33, out_valid = 1 and in_ready = 0 throughout. Raising out_ready pops 0x33 and loads the next granted word in the same cycle.
- Non-power-of-2, N = 3: in mode 0, sel = 3 produces no in_ready. In mode 1, ptr wraps 2 -> 0, giving grant sequence 0, 1, 2, 0.
- Reset mid-stream: assert rst while out_valid = 1 and out_ready = 0. Required: out_valid = 0 on the next cycle, the held word is lost, and after release the first grant goes to channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   Registered N-channel stream multiplexer with valid/ready handshaking.
//   Arbitration is either fixed (channel chosen by sel) or round-robin
//   starting from a rotating pointer. The selected word is captured into a
//   one-word output register that supports full backpressure and
//   simultaneous pop/load.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   in_data   : N*WIDTH packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, one-hot or zero
//   mode      : 0 = fixed select via sel, 1 = round-robin
//   sel       : channel index used in fixed mode
//   out_data  : held word
//   out_chan  : source channel of the held word
//   out_valid : output register holds a word
//   out_ready : consumer accepts the held word
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  // Valid vector padded to the full index range, so an out-of-range sel
  // reads a zero instead of indexing past in_valid.
  localparam int NP = 1 << SEL_W;

  logic [NP-1:0]    valid_pad_s;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] grant_s;
  logic             grant_vld_s;
  logic [SEL_W:0]   rr_sum_s;
  logic             load_en_s;
  logic             xfer_s;
  logic [WIDTH-1:0] grant_data_s;
  logic [SEL_W-1:0] next_ptr_s;

  // Zero-extend in_valid to the padded index range
  always_comb begin
    valid_pad_s        = {NP{1'b0}};
    valid_pad_s[N-1:0] = in_valid;
  end

  // Grant selection: fixed select or first valid channel scanning from ptr
  always_comb begin
    grant_s     = {SEL_W{1'b0}};
    grant_vld_s = 1'b0;
    rr_sum_s    = {(SEL_W+1){1'b0}};
    if (mode == 1'b0) begin
      if ((int'(sel) < N) && valid_pad_s[sel]) begin
        grant_s     = sel;
        grant_vld_s = 1'b1;
      end else begin
        grant_vld_s = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        // ptr < N and k < N, so one conditional subtract gives the modulo
        rr_sum_s = {1'b0, ptr_r} + (SEL_W+1)'(k);
        if (rr_sum_s >= (SEL_W+1)'(N)) begin
          rr_sum_s = rr_sum_s - (SEL_W+1)'(N);
        end else begin
          rr_sum_s = rr_sum_s;
        end
        if (!grant_vld_s && valid_pad_s[rr_sum_s[SEL_W-1:0]]) begin
          grant_s     = rr_sum_s[SEL_W-1:0];
          grant_vld_s = 1'b1;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Handshake: load when empty or being popped; reset forces ready low
  always_comb begin
    load_en_s = !out_valid || out_ready;
    xfer_s    = load_en_s && grant_vld_s && !rst;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer_s && (grant_s == SEL_W'(i));
    end
  end

  // Data mux for the granted channel and the post-transfer pointer
  always_comb begin
    grant_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant_s == SEL_W'(i)) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
    if (grant_s == SEL_W'(N-1)) begin
      next_ptr_s = {SEL_W{1'b0}};
    end else begin
      next_ptr_s = grant_s + SEL_W'(1);
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= {WIDTH{1'b0}};
      out_chan  <= {SEL_W{1'b0}};
      out_valid <= 1'b0;
      ptr_r     <= {SEL_W{1'b0}};
    end else if (xfer_s) begin
      out_data  <= grant_data_s;
      out_chan  <= grant_s;
      out_valid <= 1'b1;
      // Pointer advances in fixed mode too, so switching to round-robin
      // resumes just after the last served channel.
      ptr_r     <= next_ptr_s;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr: a 4-channel and a 3-channel
// instance sharing clock and reset, checked with immediate assertions.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;

  // 4-channel instance
  logic [31:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [7:0]  out_data4;
  logic [1:0]  out_chan4;
  logic        out_valid4;
  logic        out_ready4;

  // 3-channel instance
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int vectors;
  int miscompares;

  stream_mux_rr #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .mode(mode4), .sel(sel4),
    .out_data(out_data4), .out_chan(out_chan4), .out_valid(out_valid4),
    .out_ready(out_ready4)
  );

  stream_mux_rr #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // ---- Reset with all inputs valid ----
    rst        = 1'b1;
    mode4      = 1'b1;
    sel4       = 2'd0;
    in_data4   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid4  = 4'hF;
    out_ready4 = 1'b0;
    mode3      = 1'b1;
    sel3       = 2'd0;
    in_data3   = {8'h22, 8'h21, 8'h20};
    in_valid3  = 3'h7;
    out_ready3 = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_data", 32'(out_data4), 32'h00);
    chk("rst_in_ready", 32'(in_ready4), 32'h0);
    chk("rst_in_ready3", 32'(in_ready3), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant0", 32'(in_ready4), 32'b0001);
    chk("post_rst_grant0_n3", 32'(in_ready3), 32'b001);
    in_valid3 = 3'h0;
    out_ready3 = 1'b1;
    in_valid4  = 4'h0;

    // ---- Fixed select, sel = 2 ----
    mode4      = 1'b0;
    sel4       = 2'd2;
    in_data4   = {8'h13, 8'hA5, 8'h11, 8'h10};
    in_valid4  = 4'b0100;
    out_ready4 = 1'b1;
    #1;
    chk("fix_in_ready", 32'(in_ready4), 32'b0100);
    tick();
    chk("fix_out_data", 32'(out_data4), 32'hA5);
    chk("fix_out_chan", 32'(out_chan4), 32'd2);
    chk("fix_out_valid", 32'(out_valid4), 32'd1);

    // sel = 3 with channel 3 idle: pop only, no new word
    sel4      = 2'd3;
    in_valid4 = 4'b0000;
    #1;
    chk("fix_idle_in_ready", 32'(in_ready4), 32'h0);
    tick();
    chk("fix_idle_out_valid", 32'(out_valid4), 32'd0);
    chk("fix_idle_data_kept", 32'(out_data4), 32'hA5);

    // Serve channel 3 so the pointer wraps back to 0
    in_data4  = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid4 = 4'b1000;
    tick();
    chk("fix3_out_data", 32'(out_data4), 32'h13);
    chk("fix3_out_chan", 32'(out_chan4), 32'd3);

    // ---- Round-robin, all valid, 8 cycles ----
    mode4     = 1'b1;
    in_valid4 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_chan", 32'(out_chan4), 32'(k % 4));
      chk("rr_data", 32'(out_data4), 32'h10 + 32'(k % 4));
      chk("rr_valid", 32'(out_valid4), 32'd1);
    end

    // ---- Backpressure ----
    mode4     = 1'b0;
    sel4      = 2'd1;
    in_data4  = {8'h13, 8'h12, 8'h33, 8'h10};
    in_valid4 = 4'b0010;
    tick();
    chk("bp_load", 32'(out_data4), 32'h33);
    out_ready4 = 1'b0;
    in_valid4  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      sel4     = 2'(k);
      in_data4 = {4{8'h40 + 8'(k)}};
      #1;
      chk("bp_in_ready", 32'(in_ready4), 32'h0);
      chk("bp_out_data", 32'(out_data4), 32'h33);
      chk("bp_out_valid", 32'(out_valid4), 32'd1);
      tick();
    end
    chk("bp_hold_end", 32'(out_data4), 32'h33);
    sel4       = 2'd2;
    in_data4   = {8'h13, 8'h77, 8'h11, 8'h10};
    out_ready4 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready4), 32'b0100);
    tick();
    chk("bp_release_data", 32'(out_data4), 32'h77);
    chk("bp_release_chan", 32'(out_chan4), 32'd2);
    chk("bp_release_valid", 32'(out_valid4), 32'd1);
    in_valid4 = 4'h0;

    // ---- N = 3: out-of-range sel, then round-robin wrap ----
    mode3     = 1'b0;
    sel3      = 2'd3;
    in_valid3 = 3'h7;
    #1;
    chk("n3_sel3_ready", 32'(in_ready3), 32'h0);
    tick();
    chk("n3_sel3_valid", 32'(out_valid3), 32'd0);
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("n3_rr_chan", 32'(out_chan3), 32'(k % 3));
      chk("n3_rr_data", 32'(out_data3), 32'h20 + 32'(k % 3));
    end
    in_valid3 = 3'h0;

    // ---- Reset mid-stream ----
    mode4      = 1'b1;
    in_data4   = {8'h13, 8'h12, 8'h55, 8'h10};
    in_valid4  = 4'b0010;
    out_ready4 = 1'b0;
    tick();
    in_valid4 = 4'h0;
    tick();
    chk("mid_held_valid", 32'(out_valid4), 32'd1);
    chk("mid_held_data", 32'(out_data4), 32'h55);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready4), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(out_valid4), 32'd0);
    chk("mid_rst_data", 32'(out_data4), 32'h00);
    rst        = 1'b0;
    in_data4   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid4  = 4'hF;
    out_ready4 = 1'b1;
    #1;
    chk("mid_first_grant", 32'(in_ready4), 32'b0001);
    tick();
    chk("mid_first_chan", 32'(out_chan4), 32'd0);
    chk("mid_first_data", 32'(out_data4), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
